i2c_slave_ctrl: RTL and testbench

- Byte-level I2C slave protocol controller for the sensor I2C slave.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and shifts address and data bits.
- Drives the external 8-bit bit counter through cnt_en/cnt_load and uses its done pulse as the byte boundary.
- Reads and writes the sensor register file through a pointer that auto-increments after each data byte.

---
 rtl/i2c_slave_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_slave_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave controller and its line synchronizer.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_MACK,
        ST_WAIT_STOP,
        ST_GC_CMD,
        ST_GC_ACK
    } state_t;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h48;
    localparam logic [6:0] GC_ADDR            = 7'h00;
    localparam logic [7:0] GC_RESET_CMD       = 8'h06;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers plus history flop for SCL/SDA; registered edge, START and STOP events.
module i2c_line_sync (
    input  logic clk,
    input  logic async_rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
    logic [2:0] scl_pipe;
    logic [2:0] sda_pipe;

    logic scl_high;
    assign scl_high = scl_pipe[1] & scl_pipe[2];

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            // Pipelines reset to the idle bus level so leaving reset never fakes an edge.
            scl_pipe  <= '1;
            sda_pipe  <= '1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            scl_pipe  <= {scl_pipe[1:0], scl_in};
            sda_pipe  <= {sda_pipe[1:0], sda_in};
            scl_rise  <= scl_pipe[1] & ~scl_pipe[2];
            scl_fall  <= ~scl_pipe[1] & scl_pipe[2];
            start_det <= scl_high & ~sda_pipe[1] & sda_pipe[2];
            stop_det  <= scl_high & sda_pipe[1] & ~sda_pipe[2];
            sda_s     <= sda_pipe[1];
        end
    end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: address match, register pointer, auto-incrementing write/read bursts.
// Define GENERAL_CALL_EN to ACK general-call address 0x00 and decode the 0x06 reset command.
module i2c_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         REG_W      = 8
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [7:0]       cnt_load_val,
    input  logic             bit_cnt_done,
    output logic [REG_W-1:0] reg_ptr,
    output logic [REG_W-1:0] reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic [REG_W-1:0] reg_rdata,
    output logic             busy,
    output logic             gc_reset
);

`ifdef GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    state_t           state;
    logic [REG_W-1:0] rx_shift;
    logic [REG_W-1:0] tx_shift;
    logic             ack_drv;
    logic             mack_ok;
    logic             rd_pend;
    logic             rw_read;
    logic             gc_sel;

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic addr_hit, gc_hit;

    i2c_line_sync u_line_sync (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .sda_s       (sda_s)
    );

    assign cnt_load_val = 8'h00;
    assign addr_hit     = (rx_shift[REG_W-1:1] == SLAVE_ADDR);
    assign gc_hit       = GC_EN && (rx_shift[REG_W-1:1] == GC_ADDR) && !rx_shift[0];

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state     <= ST_IDLE;
            rx_shift  <= '0;
            tx_shift  <= '0;
            ack_drv   <= 1'b0;
            mack_ok   <= 1'b0;
            rd_pend   <= 1'b0;
            rw_read   <= 1'b0;
            gc_sel    <= 1'b0;
            sda_oe    <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_load  <= 1'b0;
            reg_ptr   <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            gc_reset  <= 1'b0;
        end else begin
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            gc_reset <= 1'b0;

            // reg_rdata is valid the cycle after reg_re, long before the next SCL fall.
            rd_pend <= reg_re;
            if (rd_pend) tx_shift <= reg_rdata;

            if (start_det) begin
                state    <= ST_ADDR;
                cnt_load <= 1'b1;
                sda_oe   <= 1'b0;
                busy     <= 1'b1;
                ack_drv  <= 1'b0;
                mack_ok  <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                ack_drv <= 1'b0;
                mack_ok <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WRITE, ST_GC_CMD: begin
                        if (scl_rise) begin
                            rx_shift <= {rx_shift[REG_W-2:0], sda_s};
                            cnt_en   <= 1'b1;
                        end
                        if (bit_cnt_done) begin
                            case (state)
                                ST_ADDR: begin
                                    if (addr_hit) begin
                                        state   <= ST_ADDR_ACK;
                                        rw_read <= rx_shift[0];
                                        reg_re  <= rx_shift[0];
                                        gc_sel  <= 1'b0;
                                    end else if (gc_hit) begin
                                        state   <= ST_ADDR_ACK;
                                        rw_read <= 1'b0;
                                        gc_sel  <= 1'b1;
                                    end else begin
                                        state <= ST_WAIT_STOP;
                                    end
                                end
                                ST_PTR: begin
                                    reg_ptr <= rx_shift;
                                    state   <= ST_PTR_ACK;
                                end
                                ST_WRITE: begin
                                    reg_wdata <= rx_shift;
                                    reg_we    <= 1'b1;
                                    state     <= ST_WRITE_ACK;
                                end
                                default: begin
                                    state <= (rx_shift == GC_RESET_CMD) ? ST_GC_ACK : ST_WAIT_STOP;
                                end
                            endcase
                        end
                    end

                    // First SCL fall drives the ACK low, the second ends the ACK bit.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WRITE_ACK, ST_GC_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oe  <= 1'b1;
                                ack_drv <= 1'b1;
                            end else begin
                                sda_oe   <= 1'b0;
                                ack_drv  <= 1'b0;
                                cnt_load <= 1'b1;
                                case (state)
                                    ST_ADDR_ACK: begin
                                        if (gc_sel) begin
                                            state <= ST_GC_CMD;
                                        end else if (rw_read) begin
                                            state    <= ST_READ;
                                            sda_oe   <= ~tx_shift[REG_W-1];
                                            tx_shift <= {tx_shift[REG_W-2:0], 1'b0};
                                        end else begin
                                            state <= ST_PTR;
                                        end
                                    end
                                    ST_PTR_ACK: state <= ST_WRITE;
                                    ST_WRITE_ACK: begin
                                        reg_ptr <= reg_ptr + 1'b1;
                                        state   <= ST_WRITE;
                                    end
                                    default: begin
                                        gc_reset <= 1'b1;
                                        state    <= ST_WAIT_STOP;
                                    end
                                endcase
                            end
                        end
                    end

                    ST_READ: begin
                        if (scl_rise) cnt_en <= 1'b1;
                        if (scl_fall) begin
                            sda_oe   <= ~tx_shift[REG_W-1];
                            tx_shift <= {tx_shift[REG_W-2:0], 1'b0};
                        end
                        if (bit_cnt_done) begin
                            state   <= ST_MACK;
                            mack_ok <= 1'b0;
                        end
                    end

                    // Release SDA for the master's ACK; on ACK, the next fall starts the new byte.
                    ST_MACK: begin
                        if (scl_fall) begin
                            if (mack_ok) begin
                                sda_oe   <= ~tx_shift[REG_W-1];
                                tx_shift <= {tx_shift[REG_W-2:0], 1'b0};
                                cnt_load <= 1'b1;
                                mack_ok  <= 1'b0;
                                state    <= ST_READ;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                        if (scl_rise) begin
                            if (!sda_s) begin
                                mack_ok <= 1'b1;
                                reg_ptr <= reg_ptr + 1'b1;
                                reg_re  <= 1'b1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_IDLE, ST_WAIT_STOP: ;

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: bus master, bit-counter and register-file models.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

`ifdef GENERAL_CALL_EN
    localparam bit GC_ON = 1'b1;
`else
    localparam bit GC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       async_rst_n = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, cnt_en, cnt_load, bit_cnt_done;
    logic [7:0] cnt_load_val, reg_ptr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_we, reg_re, busy, gc_reset;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h48), .REG_W(8)) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .cnt_en       (cnt_en),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .bit_cnt_done (bit_cnt_done),
        .reg_ptr      (reg_ptr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .busy         (busy),
        .gc_reset     (gc_reset)
    );

    // External 8-bit bit counter: done pulses the cycle after the 8th cnt_en.
    logic [3:0] cnt;
    always @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt          <= 4'd0;
            bit_cnt_done <= 1'b0;
        end else begin
            bit_cnt_done <= 1'b0;
            if (cnt_load) begin
                cnt <= 4'd0;
            end else if (cnt_en) begin
                if (cnt == 4'd7) begin
                    cnt          <= 4'd0;
                    bit_cnt_done <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // Register file model
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reg_we) mem[reg_ptr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_ptr];
    end

    // Strobe monitors
    logic [7:0] we_ptr_log[$];
    logic [7:0] we_dat_log[$];
    int         re_cnt = 0;
    int         gc_cnt = 0;
    bit         oe_seen = 1'b0;
    always @(negedge clk) begin
        if (reg_we) begin
            we_ptr_log.push_back(reg_ptr);
            we_dat_log.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (gc_reset) gc_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(5);
        s = sda_line;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~master_ack, s);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic       exp_ack;
    } addr_vec_t;

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] exp_p0;
        logic [7:0] exp_p1;
        logic [7:0] exp_final_ptr;
    } wr_vec_t;

    addr_vec_t addr_vecs [6];
    wr_vec_t   wr_vecs [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1, d2;
        logic       s;

        addr_vecs[0] = '{8'h90, 1'b1};
        addr_vecs[1] = '{8'h91, 1'b1};
        addr_vecs[2] = '{8'hA0, 1'b0};
        addr_vecs[3] = '{8'h00, GC_ON};
        addr_vecs[4] = '{8'h92, 1'b0};
        addr_vecs[5] = '{8'h10, 1'b0};

        wr_vecs[0] = '{8'h10, 8'hA5, 8'h5A, 8'h10, 8'h11, 8'h12};
        wr_vecs[1] = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h01};
        wr_vecs[2] = '{8'h7F, 8'h3C, 8'hC3, 8'h7F, 8'h80, 8'h81};

        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;

        // Reset state
        #1 async_rst_n = 1'b0;
        wait_clk(3);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_cnt_en", 32'(cnt_en), 0);
        check("rst_cnt_load", 32'(cnt_load), 0);
        check("rst_cnt_load_val", 32'(cnt_load_val), 0);
        check("rst_reg_ptr", 32'(reg_ptr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_reg_re", 32'(reg_re), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gc_reset", 32'(gc_reset), 0);
        async_rst_n = 1'b1;
        wait_clk(5);

        // Address decode table
        for (int i = 0; i < 6; i++) begin
            oe_seen = 1'b0;
            we_ptr_log.delete();
            do_start();
            send_byte(addr_vecs[i].addr_byte, a0);
            check($sformatf("addr_ack_%0h", addr_vecs[i].addr_byte), 32'(a0), 32'(addr_vecs[i].exp_ack));
            check($sformatf("addr_busy_%0h", addr_vecs[i].addr_byte), 32'(busy), 1);
            if (!addr_vecs[i].exp_ack)
                check($sformatf("addr_no_oe_%0h", addr_vecs[i].addr_byte), 32'(oe_seen), 0);
            do_stop();
            check($sformatf("addr_idle_busy_%0h", addr_vecs[i].addr_byte), 32'(busy), 0);
            check($sformatf("addr_no_we_%0h", addr_vecs[i].addr_byte), 32'(we_ptr_log.size()), 0);
        end

        // Write burst table
        for (int i = 0; i < 3; i++) begin
            we_ptr_log.delete();
            we_dat_log.delete();
            do_start();
            send_byte(8'h90, a0);
            send_byte(wr_vecs[i].ptr, a1);
            send_byte(wr_vecs[i].d0, a2);
            send_byte(wr_vecs[i].d1, a3);
            check($sformatf("wr%0d_acks", i), 32'({a0, a1, a2, a3}), 'hF);
            check($sformatf("wr%0d_busy", i), 32'(busy), 1);
            do_stop();
            check($sformatf("wr%0d_busy_after_stop", i), 32'(busy), 0);
            check($sformatf("wr%0d_we_count", i), 32'(we_ptr_log.size()), 2);
            if (we_ptr_log.size() == 2) begin
                check($sformatf("wr%0d_ptr0", i), 32'(we_ptr_log[0]), 32'(wr_vecs[i].exp_p0));
                check($sformatf("wr%0d_dat0", i), 32'(we_dat_log[0]), 32'(wr_vecs[i].d0));
                check($sformatf("wr%0d_ptr1", i), 32'(we_ptr_log[1]), 32'(wr_vecs[i].exp_p1));
                check($sformatf("wr%0d_dat1", i), 32'(we_dat_log[1]), 32'(wr_vecs[i].d1));
            end
            check($sformatf("wr%0d_final_ptr", i), 32'(reg_ptr), 32'(wr_vecs[i].exp_final_ptr));
        end

        // Combined read with repeated START: ACK then NACK
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;
        re_cnt = 0;
        do_start();
        send_byte(8'h90, a0);
        send_byte(8'h20, a1);
        do_start();
        send_byte(8'h91, a2);
        read_byte(1'b1, d0);
        read_byte(1'b0, d1);
        check("rd_acks", 32'({a0, a1, a2}), 'h7);
        check("rd_byte0", 32'(d0), 'h3C);
        check("rd_byte1", 32'(d1), 'hC3);
        oe_seen = 1'b0;
        read_byte(1'b0, d2);
        check("rd_released_line", 32'(d2), 'hFF);
        check("rd_released_oe", 32'(oe_seen), 0);
        do_stop();
        check("rd_final_ptr", 32'(reg_ptr), 'h21);
        check("rd_re_count", 32'(re_cnt), 2);

        // Address mismatch: ignored until the next START
        we_ptr_log.delete();
        re_cnt = 0;
        oe_seen = 1'b0;
        do_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_byte(8'h55, a2);
        check("mm_acks", 32'({a0, a1, a2}), 0);
        check("mm_no_oe", 32'(oe_seen), 0);
        check("mm_no_we", 32'(we_ptr_log.size()), 0);
        check("mm_no_re", 32'(re_cnt), 0);
        do_start();
        send_byte(8'h90, a0);
        send_byte(8'h05, a1);
        check("mm_restart_acks", 32'({a0, a1}), 'h3);
        do_stop();
        check("mm_restart_ptr", 32'(reg_ptr), 'h05);

        // Reset during the 4th data bit of a read of 0x00 (SDA held low)
        mem[8'h40] = 8'h00;
        do_start();
        send_byte(8'h90, a0);
        send_byte(8'h40, a1);
        do_start();
        send_byte(8'h91, a2);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        sda_m = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(3);
        check("mr_oe_before_reset", 32'(sda_oe), 1);
        #1 async_rst_n = 1'b0;
        #1;
        check("mr_oe_async_release", 32'(sda_oe), 0);
        check("mr_ptr_cleared", 32'(reg_ptr), 0);
        check("mr_busy_cleared", 32'(busy), 0);
        wait_clk(3);
        async_rst_n = 1'b1;
        wait_clk(5);
        we_ptr_log.delete();
        we_dat_log.delete();
        do_start();
        send_byte(8'h90, a0);
        send_byte(8'h50, a1);
        send_byte(8'h77, a2);
        do_stop();
        check("mr_next_acks", 32'({a0, a1, a2}), 'h7);
        check("mr_next_we_count", 32'(we_ptr_log.size()), 1);
        if (we_ptr_log.size() == 1) begin
            check("mr_next_ptr", 32'(we_ptr_log[0]), 'h50);
            check("mr_next_dat", 32'(we_dat_log[0]), 'h77);
        end

        // General call
        gc_cnt = 0;
        do_start();
        send_byte(8'h00, a0);
        send_byte(8'h06, a1);
        do_stop();
        check("gc_acks", 32'({a0, a1}), GC_ON ? 'h3 : 'h0);
        check("gc_pulses", 32'(gc_cnt), GC_ON ? 1 : 0);
        check("gc_busy_after_stop", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
